// File: rtl/spi_pkg.sv
// spi_pkg: frame width shared with the SPI slave shift stage and the master FSM encoding
package spi_pkg;
   localparam int SPI_FRAME_BITS = 24;
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: half-period divider producing tick plus SCK rise/fall strobes
module spi_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clear,
   output logic tick,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(CLK_DIV + 1);
   logic [CW-1:0] cnt;
   logic phase;
   assign tick = en && cnt == CW'(CLK_DIV - 1);
   assign rise = tick && !phase;
   assign fall = tick && phase;
   // clear realigns the phase so every state starts on a fresh low half-period
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt <= '0;
         phase <= 1'b0;
      end else if (clear) begin
         cnt <= '0;
         phase <= 1'b0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
         phase <= phase ^ tick;
      end
endmodule

// File: rtl/spi_master_frame.sv
// spi_master_frame: mode-0 SPI master moving one full-duplex frame per valid/ready handshake
module spi_master_frame
   import spi_pkg::*;
#(
   parameter int FRAME_BITS = SPI_FRAME_BITS,
   parameter int CLK_DIV = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  tx_valid,
   input  logic [FRAME_BITS-1:0] tx_data,
   output logic                  tx_ready,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  pad_cs,
   output logic                  pad_sck,
   output logic                  pad_din,
   input  logic                  pad_dout
);
   localparam int BW = $clog2(FRAME_BITS + 1);
   spi_state_t state, state_nx;
   logic [FRAME_BITS-1:0] tx_sr, rx_sr;
   logic [BW-1:0] bit_cnt;
   logic tick, rise, fall, accept, last_fall;
   assign tx_ready = state == IDLE;
   assign busy = state != IDLE;
   assign accept = tx_valid && tx_ready;
   assign last_fall = fall && bit_cnt == BW'(FRAME_BITS);
   spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
      .clk(clk),
      .reset_n(reset_n),
      .en(busy),
      .clear(state_nx != state),
      .tick(tick),
      .rise(rise),
      .fall(fall)
   );
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? SETUP : IDLE;
         SETUP:   state_nx = tick ? SHIFT : SETUP;
         SHIFT:   state_nx = last_fall ? HOLD : SHIFT;
         HOLD:    state_nx = tick ? GAP : HOLD;
         GAP:     state_nx = tick ? IDLE : GAP;
         default: state_nx = IDLE;
      endcase
   end
   // MSB goes straight to the pad at accept; tx_sr holds the bits still to come
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         tx_sr <= '0;
         rx_sr <= '0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         bit_cnt <= '0;
         pad_cs <= 1'b1;
         pad_sck <= 1'b0;
         pad_din <= 1'b0;
      end else begin
         state <= state_nx;
         rx_valid <= state == HOLD && tick;
         if (accept) begin
            tx_sr <= {tx_data[FRAME_BITS-2:0], 1'b0};
            pad_din <= tx_data[FRAME_BITS-1];
            pad_cs <= 1'b0;
            bit_cnt <= '0;
         end
         if (state == SHIFT && rise) begin
            pad_sck <= 1'b1;
            rx_sr <= {rx_sr[FRAME_BITS-2:0], pad_dout};
            bit_cnt <= bit_cnt + BW'(1);
         end
         if (state == SHIFT && fall) begin
            pad_sck <= 1'b0;
            pad_din <= tx_sr[FRAME_BITS-1];
            tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
         end
         if (state == HOLD && tick) begin
            pad_cs <= 1'b1;
            pad_din <= 1'b0;
            rx_data <= rx_sr;
         end
      end
endmodule

// File: tb/tb_spi_master_frame.sv
// tb_spi_master_frame: directed checks of the SPI master at CLK_DIV=2 and CLK_DIV=1
module tb_spi_master_frame;
   import spi_pkg::*;
   localparam int FB = SPI_FRAME_BITS;
   localparam int PERIOD2 = (2 * FB + 3) * 2;
   localparam int PERIOD1 = (2 * FB + 3) * 1;
   // back-to-back frames also spend the one IDLE cycle in which they are accepted
   localparam int B2B = PERIOD2 + 1;
   logic clk = 1'b0, reset_n = 1'b1;
   logic tx_valid = 1'b0, tx_valid1 = 1'b0;
   logic [FB-1:0] tx_data = '0, tx_data1 = '0;
   logic tx_ready, rx_valid, busy, pad_cs, pad_sck, pad_din, pad_dout;
   logic tx_ready1, rx_valid1, busy1, pad_cs1, pad_sck1, pad_din1, pad_dout1;
   logic [FB-1:0] rx_data, rx_data1;
   int checks = 0, errors = 0, cyc = 0;
   bit slave_mode = 1'b0;
   logic [FB-1:0] slv_word = 24'h123456;
   logic [FB-1:0] slv_sh, din_cap = '0;
   int sc = 0;
   int rises = 0, rises1 = 0, rxn = 0, rxn1 = 0, sck_bad = 0, cs_run = 0, cs_min = 1000;
   int rxt[$], rise1_t[$];
   logic [FB-1:0] rxq[$];
   int n, r0, v0, s;

   spi_master_frame #(.FRAME_BITS(FB), .CLK_DIV(2)) dut (
      .clk(clk), .reset_n(reset_n), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .pad_cs(pad_cs), .pad_sck(pad_sck), .pad_din(pad_din), .pad_dout(pad_dout)
   );
   spi_master_frame #(.FRAME_BITS(FB), .CLK_DIV(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .tx_valid(tx_valid1), .tx_data(tx_data1),
      .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
      .pad_cs(pad_cs1), .pad_sck(pad_sck1), .pad_din(pad_din1), .pad_dout(pad_dout1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // slave shift stage: MSB first, advances on each falling SCK while selected
   assign slv_sh = slv_word << sc;
   assign pad_dout = slave_mode ? slv_sh[FB-1] : pad_din;
   assign pad_dout1 = pad_din1;
   always @(negedge pad_sck or posedge pad_cs) sc <= pad_cs ? 0 : sc + 1;
   always @(posedge pad_sck) begin
      rises <= rises + 1;
      din_cap <= {din_cap[FB-2:0], pad_din};
      if (pad_cs) sck_bad <= sck_bad + 1;
   end
   always @(posedge pad_sck1) begin
      rises1 <= rises1 + 1;
      rise1_t.push_back(cyc);
   end
   always @(negedge clk) begin
      if (rx_valid) begin
         rxn <= rxn + 1;
         rxq.push_back(rx_data);
         rxt.push_back(cyc);
      end
      if (rx_valid1) rxn1 <= rxn1 + 1;
      if (pad_cs) cs_run <= cs_run + 1;
      else begin
         if (cs_run != 0 && cs_run < cs_min) cs_min <= cs_run;
         cs_run <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [FB-1:0] d);
      tx_data = d;
      tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_ready(output int k);
      k = 0;
      while (!tx_ready && k < 400) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
   endtask

   initial begin
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_cs", 32'(pad_cs), 32'd1);
      chk("idle_sck", 32'(pad_sck), 32'd0);
      chk("idle_din", 32'(pad_din), 32'd0);
      chk("idle_ready", 32'(tx_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rxn", rxn, 0);
      chk("idle_rx_data", 32'(rx_data), 32'd0);

      r0 = rises; v0 = rxn;
      send(24'hA5C30F);
      chk("busy_after_accept", 32'(busy), 32'd1);
      wait_ready(n);
      chk("lb_period", n, PERIOD2);
      repeat (2) @(negedge clk);
      chk("lb_rises", rises - r0, 24);
      chk("lb_din", 32'(din_cap), 32'h00A5C30F);
      chk("lb_rxn", rxn - v0, 1);
      chk("lb_rx_data", 32'(rx_data), 32'h00A5C30F);

      slave_mode = 1'b1;
      send(24'h000000);
      wait_ready(n);
      repeat (2) @(negedge clk);
      chk("slv_rx_data", 32'(rx_data), 32'h00123456);
      chk("slv_din", 32'(din_cap), 32'h00000000);
      slave_mode = 1'b0;

      v0 = rxn;
      tx_data = 24'h000001;
      tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_data = 24'h800000;
      wait_ready(n);
      @(posedge clk);
      @(negedge clk);
      tx_data = 24'hFFFFFF;
      wait_ready(n);
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      wait_ready(n);
      repeat (2) @(negedge clk);
      chk("b2b_rxn", rxn - v0, 3);
      chk("b2b_rx0", 32'(rxq[v0]), 32'h00000001);
      chk("b2b_rx1", 32'(rxq[v0+1]), 32'h00800000);
      chk("b2b_rx2", 32'(rxq[v0+2]), 32'h00FFFFFF);
      chk("b2b_gap01", rxt[v0+1] - rxt[v0], B2B);
      chk("b2b_gap12", rxt[v0+2] - rxt[v0+1], B2B);
      chk("cs_high_min", 32'(cs_min >= 2), 32'd1);

      r0 = rises; v0 = rxn;
      send(24'h3C3C3C);
      n = 0;
      while (rises - r0 < 10 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("rst_at_rise10", rises - r0, 10);
      reset_n = 1'b0;
      #1;
      chk("rst_cs", 32'(pad_cs), 32'd1);
      chk("rst_sck", 32'(pad_sck), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (110) @(negedge clk);
      chk("rst_no_rxv", rxn - v0, 0);
      r0 = rises;
      send(24'h5A5A5A);
      wait_ready(n);
      repeat (2) @(negedge clk);
      chk("post_rst_period", n, PERIOD2);
      chk("post_rst_rises", rises - r0, 24);
      chk("post_rst_rx", 32'(rx_data), 32'h005A5A5A);
      chk("post_rst_rxn", rxn - v0, 1);
      chk("sck_while_cs_high", sck_bad, 0);

      r0 = rises1;
      tx_data1 = 24'hFFFFFF;
      tx_valid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid1 = 1'b0;
      n = 0;
      while (!tx_ready1 && n < 400) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      chk("div1_period", n, PERIOD1);
      chk("div1_rises", rises1 - r0, 24);
      s = rise1_t.size();
      chk("div1_sck_period", (s >= 2) ? rise1_t[s-1] - rise1_t[s-2] : -1, 2);
      chk("div1_rx", 32'(rx_data1), 32'h00FFFFFF);
      chk("div1_rxn", rxn1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
